ri_multicycle_ctrl: RTL and testbench
=====================================

RI_MULTICYCLE_CTRL -- requirements
Module: ri_multicycle_ctrl

Interface
REQ-001 SHALL have parameter OVF_TRAP, default 1, meaning: 1 = suppress register writeback of add/sub/addi on signed overflow.
REQ-002 SHALL have parameter CNT_W, default 32, meaning: width of retired-instruction counter.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 run  input  1  1 = fetch allowed; 0 = hold in IF.
REQ-006 opcode  input  6  IR[31:26], valid from ID onward.
REQ-007 funct  input  6  IR[5:0], valid from ID onward.
REQ-008 zf  input  1  ALU zero flag, valid in EX.
REQ-009 of  input  1  ALU signed-overflow flag, valid in EX.
REQ-010 pc_write  output  1  PC load strobe.
REQ-011 pc_src  output  2  00 PC+4, 01 branch target, 10 jump target.
REQ-012 ir_write  output  1  IR load strobe.
REQ-013 reg_write  output  1  register file write strobe.
REQ-014 mem_write  output  1  data memory write strobe.
REQ-015 alu_op  output  3  000 and, 001 or, 010 xor, 011 nor, 100 add, 101 sub, 110 sltu, 111 sllv.
REQ-016 alu_srcb  output  1  0 rt data, 1 extended immediate.
REQ-017 imm_sext  output  1  1 sign-extend, 0 zero-extend immediate.
REQ-018 rd_sel  output  1  write address: 0 rd, 1 rt.
REQ-019 wb_sel  output  1  write data: 0 ALU result F, 1 M_R_Data.
REQ-020 ovf  output  1  registered overflow flag of last executed arithmetic instruction.
REQ-021 illegal  output  1  one-cycle pulse in ID for undecoded opcode/funct.
REQ-022 state  output  3  IF=0, ID=1, EX=2, MEM=3, WB=4.
REQ-023 instr_cnt  output  CNT_W  retired-instruction count.

Function
REQ-024 Decode set SHALL be: R-type (opcode 000000) funct add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, sltu 101011, sllv 000100; I-type addi 001000, andi 001100, ori 001101, xori 001110, sltiu 001011, lw 100011, sw 101011, beq 000100, j 000010; anything else illegal.
REQ-025 Outputs SHALL be Moore-style, combinational from state plus opcode/funct; all strobes 0 outside the cases listed below.
REQ-026 IF: if run=1 assert ir_write=1, pc_write=1, pc_src=00, go ID; if run=0 no strobes, stay IF.
REQ-027 ID: illegal -> pulse illegal, go IF, counter unchanged; j -> pc_write=1, pc_src=10, go IF, count retires; else go EX.
REQ-028 EX: R-type alu_op per funct, alu_srcb=0; addi/sltiu/lw/sw imm_sext=1, alu_srcb=1; andi/ori/xori imm_sext=0, alu_srcb=1; lw/sw alu_op=add.
REQ-029 EX beq: alu_op=sub, alu_srcb=0, pc_src=01, pc_write=zf, go IF, count retires.
REQ-030 EX -> MEM for lw/sw, else -> WB.
REQ-031 At EX exit, ovf SHALL load of for add/sub/addi and load 0 for every other EX instruction; ovf otherwise holds.
REQ-032 MEM: sw asserts mem_write=1, goes IF, retires; lw goes WB with no strobes.
REQ-033 WB: reg_write=1 unless OVF_TRAP=1 and ovf=1; rd_sel=1 for I-type, 0 for R-type; wb_sel=1 only for lw; go IF, retires.
REQ-034 Latency SHALL be: j 2 cycles, beq 3, ALU ops 4, sw 4, lw 5, illegal 2 (run=1 throughout).
REQ-035 instr_cnt SHALL increment by 1 on each retiring transition to IF and wrap from all-ones to 0.
REQ-036 run only affects IF; an instruction past IF always completes.

Reset
REQ-037 rst=0 SHALL asynchronously force state=IF, ovf=0, instr_cnt=0, and hold all strobes (pc_write, ir_write, reg_write, mem_write) and illegal at 0 while low, including mid-instruction.
REQ-038 After rst rises, the first rising edge with run=1 SHALL perform a fetch.

Verification
REQ-039 Reset mid-EX of add: rst=0 -> state=0, strobes 0, instr_cnt=0 immediately, without waiting for clk.
REQ-040 add with of=1, OVF_TRAP=1 -> states 0,1,2,4; ovf=1, reg_write=0 in WB; instr_cnt +1.
REQ-041 lw then sw -> lw WB has reg_write=1, wb_sel=1, rd_sel=1 (5 cycles); sw MEM has mem_write=1 (4 cycles).
REQ-042 beq with zf=1 then zf=0 -> pc_write=1, pc_src=01 in first EX; pc_write=0 in second; each 3 cycles.
REQ-043 opcode 111111 -> illegal=1 for one ID cycle, return to IF, instr_cnt unchanged.
REQ-044 run=0 for 3 cycles, then instr_cnt preset to all-ones via retirements with CNT_W=4 -> no strobes while held; counter wraps 15->0.

Source files
------------

// File: rtl/ri_multicycle_ctrl_if.sv
// Control/datapath boundary of the multicycle controller: decode fields and ALU
// flags in, strobes, mux selects, state and retirement count out.
interface ri_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zf;
  logic             of;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             reg_write;
  logic             mem_write;
  logic [2:0]       alu_op;
  logic             alu_srcb;
  logic             imm_sext;
  logic             rd_sel;
  logic             wb_sel;
  logic             ovf;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output run, opcode, funct, zf, of,
    input  pc_write, pc_src, ir_write, reg_write, mem_write, alu_op, alu_srcb,
           imm_sext, rd_sel, wb_sel, ovf, illegal, state, instr_cnt
  );

  modport slave (
    input  run, opcode, funct, zf, of,
    output pc_write, pc_src, ir_write, reg_write, mem_write, alu_op, alu_srcb,
           imm_sext, rd_sel, wb_sel, ovf, illegal, state, instr_cnt
  );
endinterface

// File: rtl/ri_multicycle_ctrl.sv
// Moore-style multicycle controller (IF/ID/EX/MEM/WB) for a small MIPS-like
// subset, with overflow trapping on writeback and a retired-instruction counter.
module ri_multicycle_ctrl #(
  parameter int OVF_TRAP = 1,
  parameter int CNT_W    = 32
) (
  input logic                 clk,
  input logic                 rst,
  ri_multicycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  typedef enum logic [4:0] {
    K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_NOR, K_SLTU, K_SLLV,
    K_ADDI, K_ANDI, K_ORI, K_XORI, K_SLTIU, K_LW, K_SW, K_BEQ, K_J, K_ILL
  } kind_e;

  function automatic kind_e decode(input logic [5:0] op, input logic [5:0] fn);
    kind_e k;
    k = K_ILL;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000: k = K_ADD;
          6'b100010: k = K_SUB;
          6'b100100: k = K_AND;
          6'b100101: k = K_OR;
          6'b100110: k = K_XOR;
          6'b100111: k = K_NOR;
          6'b101011: k = K_SLTU;
          6'b000100: k = K_SLLV;
          default:   k = K_ILL;
        endcase
      end
      6'b001000: k = K_ADDI;
      6'b001100: k = K_ANDI;
      6'b001101: k = K_ORI;
      6'b001110: k = K_XORI;
      6'b001011: k = K_SLTIU;
      6'b100011: k = K_LW;
      6'b101011: k = K_SW;
      6'b000100: k = K_BEQ;
      6'b000010: k = K_J;
      default:   k = K_ILL;
    endcase
    return k;
  endfunction

  state_e           state_q, state_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;
  kind_e            kind_s;
  logic             is_r_s;
  logic             pc_write_s, ir_write_s, reg_write_s, mem_write_s, illegal_s;
  logic [1:0]       pc_src_s;
  logic [2:0]       alu_op_s;
  logic             alu_srcb_s, imm_sext_s, rd_sel_s, wb_sel_s;

  assign kind_s    = decode(bus.opcode, bus.funct);
  assign is_r_s    = (bus.opcode == 6'b000000);
  assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next state, counter/flag updates and Moore outputs
  always_comb begin
    state_d     = state_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    pc_write_s  = 1'b0;
    pc_src_s    = 2'b00;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    illegal_s   = 1'b0;
    alu_op_s    = 3'b000;
    alu_srcb_s  = 1'b0;
    imm_sext_s  = 1'b0;
    rd_sel_s    = 1'b0;
    wb_sel_s    = 1'b0;
    case (state_q)
      S_IF: begin
        if (bus.run) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_ID;
        end else begin
          state_d = S_IF;
        end
      end
      S_ID: begin
        if (kind_s == K_ILL) begin
          illegal_s = 1'b1;
          state_d   = S_IF;
        end else if (kind_s == K_J) begin
          pc_write_s = 1'b1;
          pc_src_s   = 2'b10;
          state_d    = S_IF;
          cnt_d      = cnt_inc_s;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        case (kind_s)
          K_ADD:  alu_op_s = 3'b100;
          K_SUB:  alu_op_s = 3'b101;
          K_AND:  alu_op_s = 3'b000;
          K_OR:   alu_op_s = 3'b001;
          K_XOR:  alu_op_s = 3'b010;
          K_NOR:  alu_op_s = 3'b011;
          K_SLTU: alu_op_s = 3'b110;
          K_SLLV: alu_op_s = 3'b111;
          K_ADDI, K_LW, K_SW: begin
            alu_op_s   = 3'b100;
            imm_sext_s = 1'b1;
            alu_srcb_s = 1'b1;
          end
          K_SLTIU: begin
            alu_op_s   = 3'b110;
            imm_sext_s = 1'b1;
            alu_srcb_s = 1'b1;
          end
          K_ANDI: begin
            alu_op_s   = 3'b000;
            alu_srcb_s = 1'b1;
          end
          K_ORI: begin
            alu_op_s   = 3'b001;
            alu_srcb_s = 1'b1;
          end
          K_XORI: begin
            alu_op_s   = 3'b010;
            alu_srcb_s = 1'b1;
          end
          K_BEQ: begin
            alu_op_s   = 3'b101;
            pc_src_s   = 2'b01;
            pc_write_s = bus.zf;
          end
          default: alu_op_s = 3'b000;
        endcase
        // Only the signed arithmetic ops carry overflow forward; all others clear it
        ovf_d = (kind_s inside {K_ADD, K_SUB, K_ADDI}) ? bus.of : 1'b0;
        if (kind_s == K_BEQ) begin
          state_d = S_IF;
          cnt_d   = cnt_inc_s;
        end else if (kind_s inside {K_LW, K_SW}) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (kind_s == K_SW) begin
          mem_write_s = 1'b1;
          state_d     = S_IF;
          cnt_d       = cnt_inc_s;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_write_s = !((OVF_TRAP != 0) && ovf_q);
        rd_sel_s    = !is_r_s;
        wb_sel_s    = (kind_s == K_LW);
        state_d     = S_IF;
        cnt_d       = cnt_inc_s;
      end
      default: state_d = S_IF;
    endcase
  end

  // State, overflow flag and retirement counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are masked directly by reset so they drop without waiting for a clock
  assign bus.pc_write  = pc_write_s & rst;
  assign bus.ir_write  = ir_write_s & rst;
  assign bus.reg_write = reg_write_s & rst;
  assign bus.mem_write = mem_write_s & rst;
  assign bus.illegal   = illegal_s & rst;
  assign bus.pc_src    = pc_src_s;
  assign bus.alu_op    = alu_op_s;
  assign bus.alu_srcb  = alu_srcb_s;
  assign bus.imm_sext  = imm_sext_s;
  assign bus.rd_sel    = rd_sel_s;
  assign bus.wb_sel    = wb_sel_s;
  assign bus.ovf       = ovf_q;
  assign bus.state     = state_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_ri_multicycle_ctrl.sv
// Randomized bench: each fetched instruction is expanded into its expected
// per-cycle output trace from the ISA rules, then compared cycle by cycle.
module tb_ri_multicycle_ctrl;
  localparam int CNT_W = 4;
  localparam int C_RALU = 0, C_IALU = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_J = 5, C_ILL = 6;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         cls;
    logic [2:0] aop;
    logic       sext;
    bit         arith;
  } ins_t;

  typedef struct {
    logic [2:0]       st;
    logic             pcw;
    logic [1:0]       pcs;
    logic             irw, rw, mw;
    logic [2:0]       aop;
    logic             srcb, sext, rdsel, wbsel, ovf, ill;
    logic [CNT_W-1:0] cnt;
    bit               chk_pcs, chk_alu, chk_sext, chk_wb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ri_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
  ri_multicycle_ctrl #(.OVF_TRAP(1), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  ins_t             tbl [17];
  exp_t             expq[$];
  exp_t             trace[$];
  exp_t             ce;
  int               n_chk = 0;
  int               n_fail = 0;
  bit               cmp_en = 1'b0;
  logic             m_ovf;
  logic [CNT_W-1:0] m_cnt;

  function automatic int find(input logic [5:0] op, input logic [5:0] fn);
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].op == op && (op != 6'b000000 || tbl[i].fn == fn)) return i;
    end
    return -1;
  endfunction

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e = '{default: 0};
    e.st  = st;
    e.cnt = m_cnt;
    e.ovf = m_ovf;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Expected trace of one instruction, written from the per-phase behaviour rules
  task automatic build(input ins_t in, input int cls, input logic zf, input logic of);
    exp_t e;
    trace.delete();
    e = blank(3'd0); e.irw = 1'b1; e.pcw = 1'b1; e.pcs = 2'b00; e.chk_pcs = 1'b1;
    trace.push_back(e);
    e = blank(3'd1);
    if (cls == C_ILL) begin
      e.ill = 1'b1; trace.push_back(e); return;
    end
    if (cls == C_J) begin
      e.pcw = 1'b1; e.pcs = 2'b10; e.chk_pcs = 1'b1; trace.push_back(e);
      m_cnt = m_cnt + CNT_W'(1); return;
    end
    trace.push_back(e);
    e = blank(3'd2);
    e.chk_alu  = 1'b1;
    e.aop      = in.aop;
    e.srcb     = (cls == C_IALU || cls == C_LW || cls == C_SW);
    e.chk_sext = e.srcb;
    e.sext     = in.sext;
    if (cls == C_BEQ) begin
      e.pcw = zf; e.pcs = 2'b01; e.chk_pcs = 1'b1; trace.push_back(e);
      m_ovf = 1'b0; m_cnt = m_cnt + CNT_W'(1); return;
    end
    trace.push_back(e);
    m_ovf = in.arith ? of : 1'b0;
    if (cls == C_SW) begin
      e = blank(3'd3); e.mw = 1'b1; trace.push_back(e);
      m_cnt = m_cnt + CNT_W'(1); return;
    end
    if (cls == C_LW) trace.push_back(blank(3'd3));
    e = blank(3'd4);
    e.rw = !m_ovf; e.rdsel = (cls != C_RALU); e.wbsel = (cls == C_LW); e.chk_wb = 1'b1;
    trace.push_back(e);
    m_cnt = m_cnt + CNT_W'(1);
  endtask

  task automatic exec(input logic [5:0] op, input logic [5:0] fn, input logic zf,
                      input logic of, output int len);
    ins_t in;
    int   i;
    int   cls;
    i   = find(op, fn);
    in  = tbl[0];
    cls = C_ILL;
    if (i >= 0) begin
      in  = tbl[i];
      cls = in.cls;
    end
    bus.run = 1'b1; bus.opcode = op; bus.funct = fn; bus.zf = zf; bus.of = of;
    build(in, cls, zf, of);
    len = trace.size();
    while (trace.size() > 0) begin
      expq.push_back(trace.pop_front());
      @(posedge clk); #1;
      bus.run = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle();
    bus.run    = 1'b0;
    bus.opcode = 6'($urandom);
    bus.funct  = 6'($urandom);
    expq.push_back(blank(3'd0));
    @(posedge clk); #1;
  endtask

  // Cycle-by-cycle comparison against the expected trace
  always @(negedge clk) begin
    if (cmp_en && expq.size() > 0) begin
      ce = expq.pop_front();
      n_chk++;
      if (bus.state !== ce.st || bus.pc_write !== ce.pcw || bus.ir_write !== ce.irw ||
          bus.reg_write !== ce.rw || bus.mem_write !== ce.mw || bus.illegal !== ce.ill ||
          bus.ovf !== ce.ovf || bus.instr_cnt !== ce.cnt ||
          (ce.chk_pcs && bus.pc_src !== ce.pcs) ||
          (ce.chk_alu && (bus.alu_op !== ce.aop || bus.alu_srcb !== ce.srcb)) ||
          (ce.chk_sext && bus.imm_sext !== ce.sext) ||
          (ce.chk_wb && (bus.rd_sel !== ce.rdsel || bus.wb_sel !== ce.wbsel))) begin
        n_fail++;
        $display("FAIL cycle t=%0t got st=%0d pcw=%b pcs=%b irw=%b rw=%b mw=%b aop=%b srcb=%b sext=%b rd=%b wb=%b ovf=%b ill=%b cnt=%0d; expected st=%0d pcw=%b pcs=%b irw=%b rw=%b mw=%b aop=%b srcb=%b sext=%b rd=%b wb=%b ovf=%b ill=%b cnt=%0d",
                 $time, bus.state, bus.pc_write, bus.pc_src, bus.ir_write, bus.reg_write,
                 bus.mem_write, bus.alu_op, bus.alu_srcb, bus.imm_sext, bus.rd_sel, bus.wb_sel,
                 bus.ovf, bus.illegal, bus.instr_cnt, ce.st, ce.pcw, ce.pcs, ce.irw, ce.rw, ce.mw,
                 ce.aop, ce.srcb, ce.sext, ce.rdsel, ce.wbsel, ce.ovf, ce.ill, ce.cnt);
      end
    end
  end

  initial begin
    int         len;
    int         r;
    logic [5:0] op;
    logic [5:0] fn;
    tbl[0]  = '{6'b000000, 6'b100000, C_RALU, 3'b100, 1'b0, 1'b1};
    tbl[1]  = '{6'b000000, 6'b100010, C_RALU, 3'b101, 1'b0, 1'b1};
    tbl[2]  = '{6'b000000, 6'b100100, C_RALU, 3'b000, 1'b0, 1'b0};
    tbl[3]  = '{6'b000000, 6'b100101, C_RALU, 3'b001, 1'b0, 1'b0};
    tbl[4]  = '{6'b000000, 6'b100110, C_RALU, 3'b010, 1'b0, 1'b0};
    tbl[5]  = '{6'b000000, 6'b100111, C_RALU, 3'b011, 1'b0, 1'b0};
    tbl[6]  = '{6'b000000, 6'b101011, C_RALU, 3'b110, 1'b0, 1'b0};
    tbl[7]  = '{6'b000000, 6'b000100, C_RALU, 3'b111, 1'b0, 1'b0};
    tbl[8]  = '{6'b001000, 6'b000000, C_IALU, 3'b100, 1'b1, 1'b1};
    tbl[9]  = '{6'b001100, 6'b000000, C_IALU, 3'b000, 1'b0, 1'b0};
    tbl[10] = '{6'b001101, 6'b000000, C_IALU, 3'b001, 1'b0, 1'b0};
    tbl[11] = '{6'b001110, 6'b000000, C_IALU, 3'b010, 1'b0, 1'b0};
    tbl[12] = '{6'b001011, 6'b000000, C_IALU, 3'b110, 1'b1, 1'b0};
    tbl[13] = '{6'b100011, 6'b000000, C_LW,   3'b100, 1'b1, 1'b0};
    tbl[14] = '{6'b101011, 6'b000000, C_SW,   3'b100, 1'b1, 1'b0};
    tbl[15] = '{6'b000100, 6'b000000, C_BEQ,  3'b101, 1'b0, 1'b0};
    tbl[16] = '{6'b000010, 6'b000000, C_J,    3'b000, 1'b0, 1'b0};
    m_ovf = 1'b0;
    m_cnt = '0;

    // Reset held with run=1: fetch strobes must stay low
    rst = 1'b0; bus.run = 1'b1; bus.opcode = 6'b000000; bus.funct = 6'b100000;
    bus.zf = 1'b0; bus.of = 1'b0;
    #3;
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_strobes", {28'd0, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write}, 32'd0);
    check("reset_cnt_ovf", {27'd0, bus.instr_cnt, bus.ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b1; bus.run = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b1;

    // Directed: latencies and the key boundary cases
    exec(6'b000000, 6'b100000, 1'b0, 1'b1, len);
    check("lat_add_ovf", 32'(len), 32'd4);
    check("ovf_after_add", 32'(bus.ovf), 32'd1);
    exec(6'b100011, 6'b000000, 1'b0, 1'b1, len);
    check("lat_lw", 32'(len), 32'd5);
    exec(6'b101011, 6'b010101, 1'b0, 1'b0, len);
    check("lat_sw", 32'(len), 32'd4);
    exec(6'b000100, 6'b000000, 1'b1, 1'b0, len);
    check("lat_beq_taken", 32'(len), 32'd3);
    exec(6'b000100, 6'b000000, 1'b0, 1'b0, len);
    check("lat_beq_not", 32'(len), 32'd3);
    exec(6'b111111, 6'b000000, 1'b0, 1'b0, len);
    check("lat_illegal", 32'(len), 32'd2);
    exec(6'b000010, 6'b000000, 1'b0, 1'b0, len);
    check("lat_j", 32'(len), 32'd2);
    exec(6'b001100, 6'b000000, 1'b0, 1'b1, len);
    check("cnt_after_directed", 32'(bus.instr_cnt), 32'd7);
    for (int i = 0; i < 3; i++) idle();

    // Random instruction mix with idle gaps
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      r = $urandom_range(0, 19);
      if (r < 17) begin
        op = tbl[r].op;
        fn = (op == 6'b000000) ? tbl[r].fn : 6'($urandom);
      end else begin
        op = 6'b000000; fn = 6'b000000;
        for (int t = 0; t < 100; t++) begin
          op = 6'($urandom); fn = 6'($urandom);
          if (find(op, fn) < 0) break;
        end
      end
      exec(op, fn, 1'($urandom), 1'($urandom), len);
    end

    // Drive the counter to all-ones, then one more retirement wraps it
    for (int t = 0; t < 20 && m_cnt != {CNT_W{1'b1}}; t++) exec(6'b000010, 6'b000000, 1'b0, 1'b0, len);
    check("cnt_all_ones", 32'(bus.instr_cnt), 32'd15);
    exec(6'b000010, 6'b000000, 1'b0, 1'b0, len);
    check("cnt_wrap", 32'(bus.instr_cnt), 32'd0);
    exec(6'b001000, 6'b000000, 1'b0, 1'b0, len);

    // Asynchronous reset in the middle of an add's EX phase
    cmp_en = 1'b0;
    expq.delete();
    bus.run = 1'b1; bus.opcode = 6'b000000; bus.funct = 6'b100000; bus.of = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_ex_state", 32'(bus.state), 32'd2);
    #2 rst = 1'b0;
    #1;
    check("async_rst_state", 32'(bus.state), 32'd0);
    check("async_rst_strobes", {27'd0, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.illegal}, 32'd0);
    check("async_rst_cnt_ovf", {27'd0, bus.instr_cnt, bus.ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b1; bus.run = 1'b0;
    m_cnt = '0; m_ovf = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    exec(6'b000000, 6'b100010, 1'b0, 1'b0, len);
    check("cnt_after_recover", 32'(bus.instr_cnt), 32'd1);
    idle();
    @(negedge clk); #1;
    check("queue_drained", 32'(expq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
